// File: rtl/cluster_issue_queue.sv
// Per-cluster issue queue: takes the dispatch lanes addressed to this cluster
// and hands them out one per cycle in order.
package cluster_issue_queue_pkg;
    typedef enum logic [1:0] {
        CLUSTER_ALU = 2'd0,
        CLUSTER_LSQ = 2'd1,
        CLUSTER_FPU = 2'd2,
        CLUSTER_BRU = 2'd3
    } cluster_sel_e;

    typedef logic [7:0] uop_tag_t;

    localparam uop_tag_t UOP_INT_ALU = 8'h00;
    localparam uop_tag_t UOP_INT_MUL = 8'h01;
    localparam uop_tag_t UOP_LD_U8   = 8'h20;
    localparam uop_tag_t UOP_ST_U8   = 8'h28;
endpackage

module cluster_issue_queue
    import cluster_issue_queue_pkg::*;
#(
    parameter cluster_sel_e CLUSTER  = CLUSTER_ALU,
    parameter int unsigned  DEPTH    = 8,
    parameter int unsigned  MAX_UOPS = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      dispatch_valid_i,
    input  uop_tag_t                  dispatch_uop0_i,
    input  uop_tag_t                  dispatch_uop1_i,
    input  logic [MAX_UOPS*2-1:0]     dispatch_lane_cluster_i,
    input  logic [1:0]                dispatch_uop_count_i,
    output logic                      dispatch_ready_o,
    output logic                      issue_valid_o,
    output uop_tag_t                  issue_uop_o,
    input  logic                      issue_ready_i,
    output logic [$clog2(DEPTH):0]    occupancy_o,
    output logic [15:0]               enq_count_o,
    output logic [15:0]               stall_count_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = PW + 1;

    // Handshakes: a dispatch group transfers on a cycle with
    // dispatch_valid_i & dispatch_ready_o; the head transfers on a cycle with
    // issue_valid_o & issue_ready_i. Neither side may depend on the other.

    uop_tag_t        mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [OW-1:0]   occ;
    logic [15:0]     enq_cnt;
    logic [15:0]     stall_cnt;

    logic [3:0]      lane_cl;
    logic [1:0]      eff_count;
    logic            sel0;
    logic            sel1;
    logic            do_enq;
    logic            do_deq;
    logic [1:0]      enq_n;
    logic [OW-1:0]   free_slots;

    // Pad the lane field so lane 1 can be named even with a single lane.
    assign lane_cl = 4'(dispatch_lane_cluster_i);

    always_comb begin
        eff_count = dispatch_uop_count_i;
        if (dispatch_uop_count_i > 2'(MAX_UOPS)) begin
            eff_count = 2'(MAX_UOPS);
        end
    end

    assign sel0 = (eff_count >= 2'd1) && (cluster_sel_e'(lane_cl[1:0]) == CLUSTER);
    assign sel1 = (MAX_UOPS >= 2) && (eff_count >= 2'd2)
                  && (cluster_sel_e'(lane_cl[3:2]) == CLUSTER);

    // Ready looks only at registered occupancy so a pop never feeds back
    // into the dispatch handshake within the same cycle.
    assign free_slots       = OW'(DEPTH) - occ;
    assign dispatch_ready_o = free_slots >= OW'(MAX_UOPS);

    assign do_enq = dispatch_valid_i && dispatch_ready_o;
    assign do_deq = issue_valid_o && issue_ready_i;
    assign enq_n  = do_enq ? ({1'b0, sel0} + {1'b0, sel1}) : 2'd0;

    assign issue_valid_o = (occ != '0);
    assign issue_uop_o   = issue_valid_o ? mem[rd_ptr] : UOP_INT_ALU;
    assign occupancy_o   = occ;
    assign enq_count_o   = enq_cnt;
    assign stall_count_o = stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            enq_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PW'(enq_n);
            rd_ptr  <= rd_ptr + PW'(do_deq);
            occ     <= occ + OW'(enq_n) - OW'(do_deq);
            enq_cnt <= enq_cnt + 16'(enq_n);
            if (dispatch_valid_i && !dispatch_ready_o) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    // Lane 1 lands behind lane 0 when both are selected.
    always_ff @(posedge clk_i) begin
        if (!rst_i && do_enq) begin
            if (sel0) begin
                mem[wr_ptr] <= dispatch_uop0_i;
            end
            if (sel1) begin
                mem[wr_ptr + PW'(sel0)] <= dispatch_uop1_i;
            end
        end
    end
endmodule
